acq_sequencer: RTL

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_pkg.sv | 15 +
 rtl/sample_ram.sv | 22 ++
 rtl/acq_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared types and defaults for the acquisition sequencer and its capture buffer.
package acq_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 14;
  localparam int HOLD_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRIG,
    ST_POST,
    ST_READ,
    ST_HOLDOFF
  } state_t;
endpackage

// File: rtl/sample_ram.sv
// Simple dual-port capture buffer: one write port, one read port with a registered output.
module sample_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/acq_sequencer.sv
// Pre/post-trigger capture into a circular buffer, then a ready/valid readout of the
// full buffer starting pre_len samples before the trigger sample.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_in,
  input  logic              trig_in,
  input  logic              arm,
  input  logic              auto_arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [HOLD_W-1:0] holdoff,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W-1:0] trig_addr
);
  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_wptr, r_pre_len, r_trig_addr, r_rd_addr;
  logic [HOLD_W-1:0] r_holdoff, r_hold_cnt;
  logic [ADDR_W:0]   r_cnt;
  logic              r_vld_p0, r_last_p0;
  logic              r_rd_valid, r_rd_last;
  logic [DATA_W-1:0] r_rd_data;

  logic [ADDR_W:0]   w_post_len, w_cnt_inc;
  logic              w_we, w_hs, w_issue;
  logic [DATA_W-1:0] w_ram_q;

  assign w_post_len = DEPTH - {1'b0, r_pre_len};
  assign w_cnt_inc  = r_cnt + CNT_ONE;
  assign w_we       = !abort && (r_state == ST_PRE || r_state == ST_WAIT_TRIG || r_state == ST_POST);
  assign w_hs       = r_rd_valid && rd_ready;
  // One read in flight at most; a new one may launch on the edge that retires the output.
  assign w_issue    = (r_state == ST_READ) && !r_vld_p0 && (!r_rd_valid || w_hs) && (r_cnt != DEPTH);

  sample_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (adc_in),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_pre_len   <= '0;
      r_trig_addr <= '0;
      r_rd_addr   <= '0;
      r_holdoff   <= '0;
      r_hold_cnt  <= '0;
      r_cnt       <= '0;
      r_vld_p0    <= 1'b0;
      r_last_p0   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
    end else if (abort) begin
      r_state    <= ST_IDLE;
      r_vld_p0   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      if (w_we) r_wptr <= r_wptr + ADDR_ONE;
      // p0 -> output register boundary
      r_vld_p0 <= w_issue;
      if (r_vld_p0) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_ram_q;
        r_rd_last  <= r_last_p0;
      end else if (w_hs) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state   <= ST_PRE;
            r_pre_len <= pre_len;
            r_holdoff <= holdoff;
            r_cnt     <= '0;
          end
        end
        ST_PRE: begin
          if ({1'b0, r_pre_len} <= w_cnt_inc) r_state <= ST_WAIT_TRIG;
          else r_cnt <= w_cnt_inc;
        end
        ST_WAIT_TRIG: begin
          if (trig_in) begin
            r_trig_addr <= r_wptr;
            r_rd_addr   <= r_wptr - r_pre_len;
            // With pre_len = D-1 the trigger sample is the only post sample.
            if (w_post_len == CNT_ONE) begin
              r_state <= ST_READ;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_POST;
              r_cnt   <= CNT_ONE;
            end
          end
        end
        ST_POST: begin
          if (w_cnt_inc == w_post_len) begin
            r_state <= ST_READ;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_rd_addr <= r_rd_addr + ADDR_ONE;
            r_cnt     <= w_cnt_inc;
            r_last_p0 <= (w_cnt_inc == DEPTH);
          end
          if (w_hs && r_rd_last) begin
            r_state    <= ST_HOLDOFF;
            r_hold_cnt <= '0;
          end
        end
        ST_HOLDOFF: begin
          if (r_hold_cnt == r_holdoff) begin
            if (auto_arm) begin
              r_state   <= ST_PRE;
              r_pre_len <= pre_len;
              r_holdoff <= holdoff;
              r_cnt     <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign trig_addr = r_trig_addr;
endmodule
